// File: rtl/cyclic_encoder_seq_if.sv
// Handshake bundle for the cyclic encoder/checker: an input word channel
// (valid/ready with mode and data) and a result channel (valid/ready with
// data and error flag). The master is the side that supplies words and
// consumes results; the slave is the encoder itself.
interface cyclic_encoder_seq_if #(
  parameter int N = 15
);
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/cyclic_encoder_seq.sv
// Sequential systematic encoder / syndrome checker for binary cyclic codes.
// An LFSR divider consumes BPC information bits per cycle, MSB first, and
// produces the remainder of i(x)*x^M mod g(x). In encode mode that remainder
// is the parity; in check mode it is XORed with the received parity to form
// the syndrome. Codeword layout: parity in [N-1:K], information in [K-1:0].
module cyclic_encoder_seq #(
  parameter int             N     = 15,
  parameter int             K     = 7,
  parameter logic [N-K:0]   GPOLY = 9'b1_1101_0001,
  parameter int             BPC   = 1
) (
  input  logic                clk,
  input  logic                rst,
  cyclic_encoder_seq_if.slave bus
);
  localparam int           M    = N - K;
  localparam int           NCYC = K / BPC;
  localparam int           CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [M-1:0] GLOW = GPOLY[M-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [M-1:0]   r_reg;
  logic [CW-1:0]  cnt_reg;
  logic [K-1:0]   info_reg;
  logic [M-1:0]   par_rx_reg;
  logic           mode_reg;
  logic [N-1:0]   out_data_reg;
  logic           out_err_reg;

  logic           accept;
  logic           last;
  logic           in_ready_c;
  logic           out_valid_c;
  logic [K-1:0]   info_rot;
  logic [BPC-1:0] bits_cur;
  logic [M-1:0]   r_next;
  logic [M-1:0]   syn;

  // The info word is rotated left by BPC each RUN cycle so the next bits to
  // feed always sit at the top; after NCYC rotations it is back in place,
  // which lets the original info be emitted without a second copy.
  generate
    if (BPC < K) begin : g_rot
      assign info_rot = {info_reg[K-BPC-1:0], info_reg[K-1:K-BPC]};
    end else begin : g_norot
      assign info_rot = info_reg;
    end
  endgenerate

  assign bits_cur = info_reg[K-1 -: BPC];

  // BPC divider steps chained combinationally, highest-order bit first.
  always_comb begin
    logic [M-1:0] acc;
    acc = r_reg;
    for (int b = 0; b < BPC; b++) begin
      acc = {acc[M-2:0], 1'b0} ^ ((bits_cur[BPC-1-b] ^ acc[M-1]) ? GLOW : '0);
    end
    r_next = acc;
  end

  assign syn = r_next ^ par_rx_reg;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs, decoded from registered state only.
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    last        = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CW'(NCYC - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the word on accept, step the divider in RUN, and load
  // the result registers on the final RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg        <= '0;
      cnt_reg      <= '0;
      info_reg     <= '0;
      par_rx_reg   <= '0;
      mode_reg     <= 1'b0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
    end else if (accept) begin
      info_reg   <= bus.in_data[K-1:0];
      par_rx_reg <= bus.in_data[N-1:K];
      mode_reg   <= bus.in_mode;
      r_reg      <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      r_reg    <= r_next;
      info_reg <= info_rot;
      cnt_reg  <= cnt_reg + 1'b1;
      if (last) begin
        out_data_reg <= {(mode_reg ? syn : r_next), info_rot};
        out_err_reg  <= mode_reg & (|syn);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_reg;
  assign bus.out_err   = out_err_reg;
endmodule

// File: tb/tb_cyclic_encoder_seq.sv
// Bench for cyclic_encoder_seq: directed and randomized words on a BPC=1
// instance plus a BPC=7 instance, compared against a polynomial long-division
// reference model.
module tb_cyclic_encoder_seq;
  localparam logic [8:0] GP = 9'h1D1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic [14:0] cws [0:127];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cyclic_encoder_seq_if #(.N(15)) a ();
  cyclic_encoder_seq_if #(.N(15)) b ();

  cyclic_encoder_seq #(.N(15), .K(7), .GPOLY(GP), .BPC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  cyclic_encoder_seq #(.N(15), .K(7), .GPOLY(GP), .BPC(7)) dut7 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // Remainder of info(x)*x^8 mod g(x) by long division on the whole word.
  function automatic logic [7:0] ref_parity(input logic [6:0] info);
    logic [14:0] v;
    v = {info, 8'h00};
    for (int bi = 14; bi >= 8; bi--) begin
      if (v[bi]) v = v ^ ({6'b0, GP} << (bi - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [14:0] ref_enc(input logic [6:0] info);
    return {ref_parity(info), info};
  endfunction

  function automatic logic [7:0] ref_syn(input logic [14:0] rx);
    return ref_parity(rx[6:0]) ^ rx[14:7];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one word on channel a (called at a negedge); returns at the
  // negedge after the accept edge.
  task automatic send(input logic mode, input logic [14:0] data);
    int guard;
    guard = 0;
    while (!a.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(guard < 50), 32'd1);
    a.in_mode  = mode;
    a.in_data  = data;
    a.in_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc   = cyc;
    a.in_valid = 1'b0;
    a.in_data  = 15'($urandom);
    a.in_mode  = 1'($urandom);
    @(negedge clk);
  endtask

  // Count accept-relative edges until out_valid is seen at a negedge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!a.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take();
    a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    a.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_word(input logic mode, input logic [14:0] data, input int rdy_delay,
                          output logic [14:0] od, output logic oe, output int lat);
    send(mode, data);
    wait_valid(lat);
    od = a.out_data;
    oe = a.out_err;
    repeat (rdy_delay) @(negedge clk);
    take();
  endtask

  initial begin
    logic [14:0] od;
    logic        oe;
    int          lat;
    int          n;
    int          acc_prev;
    logic [14:0] rx;
    logic [14:0] e;
    logic [6:0]  info;
    logic        mode;
    logic [7:0]  s;

    a.in_valid = 1'b0; a.in_mode = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_mode = 1'b0; b.in_data = '0; b.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_out_data", 32'(a.out_data), 32'd0);
    chk("rst_out_err", 32'(a.out_err), 32'd0);
    chk("rst_in_ready", 32'(a.in_ready), 32'd1);
    chk("rst_b_out_valid", 32'(b.out_valid), 32'd0);

    // Unit vectors, all-ones, zero
    run_word(1'b0, 15'h0001, 0, od, oe, lat);
    chk("unit0_data", 32'(od), 32'h6881);
    chk("unit0_lat", 32'(lat), 32'd7);
    run_word(1'b0, 15'h0002, 0, od, oe, lat);
    chk("unit1_data", 32'(od), 32'h3982);
    chk("unit1_lat", 32'(lat), 32'd7);
    run_word(1'b0, 15'h007F, 0, od, oe, lat);
    chk("ones_data", 32'(od), 32'h7FFF);
    chk("ones_err", 32'(oe), 32'd0);
    run_word(1'b0, 15'h0000, 0, od, oe, lat);
    chk("zero_data", 32'(od), 32'h0000);

    // Error detection
    run_word(1'b1, 15'h6881 ^ 15'h0400, 0, od, oe, lat);
    chk("errp3_err", 32'(oe), 32'd1);
    chk("errp3_syn", 32'(od[14:7]), 32'h08);
    chk("errp3_info", 32'(od[6:0]), 32'h01);
    run_word(1'b1, 15'h6881 ^ 15'h0001, 0, od, oe, lat);
    chk("erri0_err", 32'(oe), 32'd1);
    chk("erri0_syn", 32'(od[14:7]), 32'hD1);

    // Exhaustive encode, upper input bits randomized (must be ignored)
    for (int i = 0; i < 128; i++) begin
      info = 7'(i);
      run_word(1'b0, {8'($urandom), info}, 0, od, oe, lat);
      cws[i] = od;
      chk($sformatf("enc_cw[%0d]", i), 32'(od), 32'(ref_enc(info)));
      chk($sformatf("enc_c7[%0d]", i), 32'(od[7]), 32'(info[0] ^ info[1] ^ info[3]));
      chk($sformatf("enc_c11[%0d]", i), 32'(od[11]),
          32'(info[0] ^ info[1] ^ info[3] ^ info[4] ^ info[5]));
      chk($sformatf("enc_err[%0d]", i), 32'(oe), 32'd0);
    end
    // Every codeword checks clean
    for (int i = 0; i < 128; i++) begin
      run_word(1'b1, cws[i], 0, od, oe, lat);
      chk($sformatf("chk_err[%0d]", i), 32'(oe), 32'd0);
      chk($sformatf("chk_syn[%0d]", i), 32'(od[14:7]), 32'd0);
      chk($sformatf("chk_info[%0d]", i), 32'(od[6:0]), 32'(i));
    end

    // Back-pressure: 20 cycles in DONE with out_ready low
    send(1'b0, 15'h0055);
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd7);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("bp_data[%0d]", k), 32'(a.out_data), 32'(ref_enc(7'h55)));
      chk($sformatf("bp_in_ready[%0d]", k), 32'(a.in_ready), 32'd0);
      chk($sformatf("bp_valid[%0d]", k), 32'(a.out_valid), 32'd1);
    end
    take();

    // in_valid toggling during RUN must not cause another acceptance
    send(1'b0, 15'h0013);
    lat = 0;
    while (!a.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      a.in_valid = 1'($urandom);
      a.in_data  = 15'($urandom);
      a.in_mode  = 1'($urandom);
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    chk("tog_lat", 32'(lat), 32'd7);
    chk("tog_data", 32'(a.out_data), 32'(ref_enc(7'h13)));
    take();
    chk("tog_idle_ready", 32'(a.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("tog_idle_valid", 32'(a.out_valid), 32'd0);

    // Back-to-back with out_ready held high
    a.out_ready = 1'b1;
    acc_prev = 0;
    for (int w = 0; w < 4; w++) begin
      info = 7'($urandom);
      send(1'b0, {8'h00, info});
      if (w > 0) chk($sformatf("b2b_ii[%0d]", w), 32'(last_acc - acc_prev), 32'd9);
      acc_prev = last_acc;
      wait_valid(lat);
      chk($sformatf("b2b_lat[%0d]", w), 32'(lat), 32'd7);
      chk($sformatf("b2b_data[%0d]", w), 32'(a.out_data), 32'(ref_enc(info)));
      @(negedge clk);
      chk($sformatf("b2b_onecyc[%0d]", w), 32'(a.out_valid), 32'd0);
      chk($sformatf("b2b_ready[%0d]", w), 32'(a.in_ready), 32'd1);
    end
    a.out_ready = 1'b0;

    // Randomized words, modes, error patterns and back-pressure
    for (int k = 0; k < 40; k++) begin
      mode = 1'($urandom);
      info = 7'($urandom);
      if (!mode) begin
        rx = {8'($urandom), info};
      end else begin
        case ($urandom_range(0, 2))
          0:       e = 15'h0000;
          1:       e = 15'd1 << $urandom_range(0, 14);
          default: e = 15'($urandom);
        endcase
        rx = ref_enc(info) ^ e;
      end
      run_word(mode, rx, $urandom_range(0, 3), od, oe, lat);
      s = ref_syn(rx);
      chk($sformatf("rnd_lat[%0d]", k), 32'(lat), 32'd7);
      if (!mode) begin
        chk($sformatf("rnd_enc[%0d]", k), 32'(od), 32'(ref_enc(info)));
        chk($sformatf("rnd_enc_err[%0d]", k), 32'(oe), 32'd0);
      end else begin
        chk($sformatf("rnd_chk[%0d]", k), 32'(od), 32'({s, rx[6:0]}));
        chk($sformatf("rnd_chk_err[%0d]", k), 32'(oe), 32'(|s));
      end
    end

    // Reset in the third RUN cycle drops the word
    send(1'b0, 15'h0033);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(a.out_valid), 32'd0);
    chk("mrst_ready", 32'(a.in_ready), 32'd1);
    chk("mrst_data", 32'(a.out_data), 32'd0);
    chk("mrst_err", 32'(a.out_err), 32'd0);
    a.out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a.out_valid) n++;
    end
    a.out_ready = 1'b0;
    chk("mrst_no_output", 32'(n), 32'd0);

    // BPC=7 instance: single-cycle RUN
    for (int k = 0; k < 11; k++) begin
      mode = (k == 0) ? 1'b0 : 1'($urandom);
      rx   = (k == 0) ? 15'h0002 : 15'($urandom);
      chk($sformatf("b7_ready[%0d]", k), 32'(b.in_ready), 32'd1);
      b.in_mode  = mode;
      b.in_data  = rx;
      b.in_valid = 1'b1;
      @(posedge clk);
      #1 b.in_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!b.out_valid && lat < 50) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk($sformatf("b7_lat[%0d]", k), 32'(lat), 32'd1);
      if (!mode) begin
        chk($sformatf("b7_enc[%0d]", k), 32'(b.out_data), 32'(ref_enc(rx[6:0])));
        chk($sformatf("b7_enc_err[%0d]", k), 32'(b.out_err), 32'd0);
      end else begin
        s = ref_syn(rx);
        chk($sformatf("b7_chk[%0d]", k), 32'(b.out_data), 32'({s, rx[6:0]}));
        chk($sformatf("b7_chk_err[%0d]", k), 32'(b.out_err), 32'(|s));
      end
      b.out_ready = 1'b1;
      @(posedge clk);
      #1 b.out_ready = 1'b0;
      @(negedge clk);
    end
    chk("b7_first_known", 32'(cws[2]), 32'h3982);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
